// File: rtl/avalon_bus_bridge.sv
// Bridges a held request/acknowledge user port onto an Avalon-MM master with posted writes.
// Define BRIDGE_TIMEOUT_EN to bound Avalon stalls to TIMEOUT cycles.
module avalon_bus_bridge #(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   bridge_address,
  input  logic [DATA_W/8-1:0] bridge_byte_enable,
  input  logic                bridge_read,
  input  logic                bridge_write,
  input  logic [DATA_W-1:0]   bridge_write_data,
  output logic                bridge_acknowledge,
  output logic [DATA_W-1:0]   bridge_read_data,
  output logic                bridge_busy,
  output logic                bridge_error,
  input  logic                error_clear,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_read,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;
  localparam int unsigned ENT_W = ADDR_W + BE_W + DATA_W;

  typedef enum logic [2:0] {StIdle, StDrain, StRdReq, StRdWait, StAck} state_e;

  state_e            state_q, state_d;
  logic [ENT_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [ENT_W-1:0]  head;
  logic              fifo_full, fifo_empty, push, pop;
  logic              wr_timeout, rd_timeout;
  logic              err_q, err_d, err_set;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [BE_W-1:0]   req_be_q, req_be_d;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
  assign head       = fifo_mem[rd_ptr_q[IDX_W-1:0]];
  // A timed-out head entry is dropped exactly like a completed one.
  assign pop        = !fifo_empty && (!avm_waitrequest || wr_timeout);

  always_ff @(posedge clk_clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q[IDX_W-1:0]] <= {bridge_address, bridge_byte_enable, bridge_write_data};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;
  logic             wr_stall, rd_active;

  assign wr_stall   = !fifo_empty && avm_waitrequest;
  assign rd_active  = (state_q == StRdReq) || (state_q == StRdWait);
  assign wr_timeout = wr_stall && (wr_cnt_q >= CNT_W'(TIMEOUT - 1));
  // The read count spans both read states, so >= catches acceptance on the last cycle.
  assign rd_timeout = rd_active && (rd_cnt_q >= CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= (wr_stall && !wr_timeout) ? wr_cnt_q + CNT_W'(1) : '0;
      rd_cnt_q <= (rd_active && state_d != StAck) ? rd_cnt_q + CNT_W'(1) : '0;
    end
  end
`else
  logic unused_timeout;

  assign wr_timeout     = 1'b0;
  assign rd_timeout     = 1'b0;
  assign unused_timeout = (TIMEOUT == 0);
`endif

  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    err_set    = 1'b0;
    rdata_d    = rdata_q;
    req_addr_d = req_addr_q;
    req_be_d   = req_be_q;
    unique case (state_q)
      StIdle: begin
        if (bridge_read && bridge_write) begin
          err_set = 1'b1;
          rdata_d = '1;
          state_d = StAck;
        end else if (bridge_write) begin
          // A pop in the same cycle frees the slot even when the FIFO reads full.
          if (!fifo_full || pop) begin
            push    = 1'b1;
            state_d = StAck;
          end
        end else if (bridge_read) begin
          req_addr_d = bridge_address;
          req_be_d   = bridge_byte_enable;
          state_d    = StDrain;
        end
      end
      StDrain: begin
        if (fifo_empty) state_d = StRdReq;
      end
      StRdReq: begin
        if (!avm_waitrequest) begin
          state_d = StRdWait;
        end else if (rd_timeout) begin
          err_set = 1'b1;
          rdata_d = '1;
          state_d = StAck;
        end
      end
      StRdWait: begin
        if (avm_readdatavalid) begin
          rdata_d = avm_readdata;
          state_d = StAck;
        end else if (rd_timeout) begin
          err_set = 1'b1;
          rdata_d = '1;
          state_d = StAck;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign err_d = err_set || wr_timeout || (err_q && !error_clear);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= StIdle;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      req_addr_q <= '0;
      req_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      req_addr_q <= req_addr_d;
      req_be_q   <= req_be_d;
    end
  end

  // Reads only issue once the FIFO is empty, so read and write never overlap.
  always_comb begin
    avm_write      = !fifo_empty;
    avm_read       = (state_q == StRdReq);
    avm_address    = '0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    if (!fifo_empty) begin
      {avm_address, avm_byteenable, avm_writedata} = head;
    end else if (state_q == StRdReq) begin
      avm_address    = req_addr_q;
      avm_byteenable = req_be_q;
    end
  end

  assign bridge_acknowledge = (state_q == StAck);
  assign bridge_busy        = (state_q != StIdle) || fifo_full;
  assign bridge_error       = err_q;
  assign bridge_read_data   = rdata_q;

endmodule

// File: tb/tb_avalon_bus_bridge.sv
// Directed self-checking bench for avalon_bus_bridge; the timeout scenario needs BRIDGE_TIMEOUT_EN.
module tb_avalon_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [25:0] address = '0;
  logic [1:0]  byte_enable = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [15:0] write_data = '0;
  logic        ack;
  logic [15:0] read_data;
  logic        busy, error;
  logic        err_clr = 1'b0;
  logic [25:0] avm_address;
  logic [1:0]  avm_byteenable;
  logic        avm_read, avm_write;
  logic [15:0] avm_writedata;
  logic        waitreq = 1'b0;
  logic [15:0] readdata = '0;
  logic        rdv = 1'b0;

  int checks = 0;
  int failures = 0;
  int pops = 0;
  int both = 0;

  avalon_bus_bridge #(
    .ADDR_W(26), .DATA_W(16), .FIFO_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .bridge_address(address), .bridge_byte_enable(byte_enable),
    .bridge_read(read), .bridge_write(write), .bridge_write_data(write_data),
    .bridge_acknowledge(ack), .bridge_read_data(read_data),
    .bridge_busy(busy), .bridge_error(error), .error_clear(err_clr),
    .avm_address(avm_address), .avm_byteenable(avm_byteenable),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_waitrequest(waitreq), .avm_readdata(readdata), .avm_readdatavalid(rdv)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (avm_write && !waitreq) pops <= pops + 1;
    if (avm_read && avm_write) both <= both + 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    step;
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL reset_ack got %b want 0", ack); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL reset_error got %b want 0", error); end
    checks++; if (read_data !== 16'h0) begin failures++; $display("FAIL reset_rdata got %h want 0000", read_data); end
    checks++; if ({avm_read, avm_write} !== 2'b00) begin failures++; $display("FAIL reset_avm_cmd got %b want 00", {avm_read, avm_write}); end
    checks++; if (avm_address !== 26'h0) begin failures++; $display("FAIL reset_avm_addr got %h want 0", avm_address); end
    rst_n = 1'b1;
    step;
  endtask

  task automatic test_single_write;
    address = 26'h10; write_data = 16'hA5A5; byte_enable = 2'b11; waitreq = 1'b0; write = 1'b1;
    step;
    write = 1'b0;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL wr_ack got %b want 1", ack); end
    checks++; if (avm_write !== 1'b1) begin failures++; $display("FAIL wr_avm_write got %b want 1", avm_write); end
    checks++; if (avm_address !== 26'h10) begin failures++; $display("FAIL wr_avm_addr got %h want 10", avm_address); end
    checks++; if (avm_writedata !== 16'hA5A5) begin failures++; $display("FAIL wr_avm_data got %h want a5a5", avm_writedata); end
    checks++; if (avm_byteenable !== 2'b11) begin failures++; $display("FAIL wr_avm_be got %b want 11", avm_byteenable); end
    step;
    checks++; if ({ack, avm_write} !== 2'b00) begin failures++; $display("FAIL wr_done got %b want 00", {ack, avm_write}); end
  endtask

  task automatic test_fifo_full;
    waitreq = 1'b1; byte_enable = 2'b11;
    for (int i = 0; i < 4; i++) begin
      address = 26'h100 + 26'(2 * i); write_data = 16'h1000 + 16'(i); write = 1'b1;
      step;
      write = 1'b0;
      checks++; if (ack !== 1'b1) begin failures++; $display("FAIL full_ack%0d got %b want 1", i, ack); end
      step;
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy got %b want 1", busy); end
    address = 26'h108; write_data = 16'h1004; write = 1'b1;
    step;
    step;
    checks++; if ({ack, busy} !== 2'b01) begin failures++; $display("FAIL full_hold got ack,busy=%b want 01", {ack, busy}); end
    checks++; if (avm_address !== 26'h100) begin failures++; $display("FAIL full_head got %h want 100", avm_address); end
    waitreq = 1'b0;
    step;
    write = 1'b0;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL full_late_ack got %b want 1", ack); end
    for (int i = 1; i < 5; i++) begin
      checks++;
      if (avm_write !== 1'b1 || avm_address !== 26'h100 + 26'(2 * i) ||
          avm_writedata !== 16'h1000 + 16'(i)) begin
        failures++;
        $display("FAIL full_drain%0d got w=%b a=%h d=%h want w=1 a=%h d=%h", i, avm_write,
                 avm_address, avm_writedata, 26'h100 + 26'(2 * i), 16'h1000 + 16'(i));
      end
      step;
    end
    checks++; if (avm_write !== 1'b0) begin failures++; $display("FAIL full_empty got %b want 0", avm_write); end
  endtask

  task automatic test_read_ordering;
    int base;
    int n;
    base = pops;
    waitreq = 1'b1; byte_enable = 2'b11;
    for (int i = 0; i < 2; i++) begin
      address = 26'h40 + 26'(2 * i); write_data = 16'h2000 + 16'(i); write = 1'b1;
      step;
      write = 1'b0;
      step;
    end
    address = 26'h20; read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step;
      checks++; if (avm_read !== 1'b0) begin failures++; $display("FAIL ord_early_read%0d got %b want 0", i, avm_read); end
    end
    waitreq = 1'b0;
    n = 0;
    while (!avm_read && n < 20) begin
      step;
      n++;
    end
    checks++; if (avm_read !== 1'b1) begin failures++; $display("FAIL ord_read_seen got %b want 1", avm_read); end
    checks++; if (pops - base !== 2) begin failures++; $display("FAIL ord_writes_done got %0d want 2", pops - base); end
    checks++; if (avm_address !== 26'h20) begin failures++; $display("FAIL ord_rd_addr got %h want 20", avm_address); end
    step;
    step;
    readdata = 16'h1234; rdv = 1'b1;
    step;
    rdv = 1'b0; read = 1'b0;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL ord_ack got %b want 1", ack); end
    checks++; if (read_data !== 16'h1234) begin failures++; $display("FAIL ord_rdata got %h want 1234", read_data); end
    step;
  endtask

  task automatic test_conflict;
    read = 1'b1; write = 1'b1; address = 26'h50; write_data = 16'h7777;
    step;
    read = 1'b0; write = 1'b0;
    checks++; if (ack !== 1'b1) begin failures++; $display("FAIL conf_ack got %b want 1", ack); end
    checks++; if (read_data !== 16'hFFFF) begin failures++; $display("FAIL conf_rdata got %h want ffff", read_data); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL conf_err got %b want 1", error); end
    checks++; if ({avm_read, avm_write} !== 2'b00) begin failures++; $display("FAIL conf_no_access got %b want 00", {avm_read, avm_write}); end
    step;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    checks++; if (error !== 1'b0) begin failures++; $display("FAIL conf_clear got %b want 0", error); end
    read = 1'b1; write = 1'b1; err_clr = 1'b1;
    step;
    read = 1'b0; write = 1'b0; err_clr = 1'b0;
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL conf_set_wins got %b want 1", error); end
    step;
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
  endtask

  task automatic test_timeout;
`ifdef BRIDGE_TIMEOUT_EN
    int n;
    waitreq = 1'b0; address = 26'h30; read = 1'b1;
    n = 0;
    while (!ack && n < 12) begin
      step;
      n++;
    end
    read = 1'b0;
    checks++; if (n !== 10 || ack !== 1'b1) begin failures++; $display("FAIL to_rd_ack got cycles=%0d ack=%b want 10,1", n, ack); end
    checks++; if (read_data !== 16'hFFFF) begin failures++; $display("FAIL to_rd_data got %h want ffff", read_data); end
    checks++; if (error !== 1'b1) begin failures++; $display("FAIL to_rd_err got %b want 1", error); end
    readdata = 16'h5555; rdv = 1'b1;
    step;
    step;
    rdv = 1'b0;
    checks++; if (read_data !== 16'hFFFF || ack !== 1'b0) begin failures++; $display("FAIL to_late_rdv got d=%h ack=%b want ffff,0", read_data, ack); end
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    waitreq = 1'b1; address = 26'h70; write_data = 16'h0BAD; write = 1'b1;
    step;
    write = 1'b0;
    for (int i = 0; i < 7; i++) step;
    checks++; if ({avm_write, error} !== 2'b10) begin failures++; $display("FAIL to_wr_pending got w,err=%b want 10", {avm_write, error}); end
    step;
    checks++; if ({avm_write, error} !== 2'b01) begin failures++; $display("FAIL to_wr_drop got w,err=%b want 01", {avm_write, error}); end
    waitreq = 1'b0; err_clr = 1'b1;
    step;
    err_clr = 1'b0;
`endif
  endtask

  task automatic test_reset_mid;
    int act;
    waitreq = 1'b0; address = 26'h60; byte_enable = 2'b01; read = 1'b1;
    step;
    step;
    step;
    checks++; if ({avm_read, busy} !== 2'b01) begin failures++; $display("FAIL mid_rdwait got rd,busy=%b want 01", {avm_read, busy}); end
    rst_n = 1'b0;
    #1;
    read = 1'b0;
    checks++; if ({ack, busy, error, avm_read, avm_write} !== 5'b0) begin failures++; $display("FAIL mid_rst_ctrl got %b want 00000", {ack, busy, error, avm_read, avm_write}); end
    checks++; if (read_data !== 16'h0) begin failures++; $display("FAIL mid_rst_rdata got %h want 0000", read_data); end
    step;
    rst_n = 1'b1;
    waitreq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      address = 26'h80 + 26'(2 * i); write_data = 16'h3000 + 16'(i); write = 1'b1;
      step;
      write = 1'b0;
      step;
    end
    address = 26'h90; read = 1'b1;
    step;
    step;
    rst_n = 1'b0;
    #1;
    read = 1'b0;
    checks++; if ({ack, busy, avm_read, avm_write} !== 4'b0) begin failures++; $display("FAIL mid_rst_q got %b want 0000", {ack, busy, avm_read, avm_write}); end
    checks++; if (avm_address !== 26'h0) begin failures++; $display("FAIL mid_rst_addr got %h want 0", avm_address); end
    step;
    rst_n = 1'b1; waitreq = 1'b0;
    act = 0;
    for (int i = 0; i < 8; i++) begin
      step;
      if (avm_read || avm_write || ack) act++;
    end
    checks++; if (act !== 0) begin failures++; $display("FAIL mid_no_replay got %0d active cycles want 0", act); end
  endtask

  task automatic test_protocol;
    checks++; if (both !== 0) begin failures++; $display("FAIL rd_wr_overlap got %0d cycles want 0", both); end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_fifo_full;
    test_read_ordering;
    test_conflict;
    test_timeout;
    test_reset_mid;
    test_protocol;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
